// File: rtl/full_adder_pkg.sv
// Shared definitions for the one-bit full adder slice.
`timescale 1ns/1ps

package full_adder_pkg;

    // Width of the arithmetic result {carry, sum} of a one-bit add.
    localparam int unsigned FA_RES_W = 2;

    // Registered adder result: carry in the upper bit, sum in the lower bit.
    typedef struct packed {
        logic co;
        logic s;
    } fa_res_t;

endpackage : full_adder_pkg

// File: rtl/full_adder_half_adder.sv
// Half adder built from gate primitives so X/Z on an input reaches the outputs.
`timescale 1ns/1ps

module half_adder
    import full_adder_pkg::*;
(
    output logic S,
    output logic C,
    input  logic A,
    input  logic B
);

    xor u_sum   (S, A, B);
    and u_carry (C, A, B);

endmodule : half_adder

// File: rtl/full_adder.sv
// One-bit full adder: two half adders plus an OR, with a registered copy of
// the result that only the active-low asynchronous reset clears.
`timescale 1ns/1ps

module full_adder
    import full_adder_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic A,
    input  logic B,
    input  logic CI,
    output logic S,
    output logic CO,
    output logic S_Q,
    output logic CO_Q
);

    logic    p;      // propagate: A xor B
    logic    g;      // generate: A and B
    logic    t;      // carry produced by the second half adder
    fa_res_t res_d;
    fa_res_t res_q;

    half_adder u_ha1 (
        .S (p),
        .C (g),
        .A (A),
        .B (B)
    );

    half_adder u_ha2 (
        .S (S),
        .C (t),
        .A (p),
        .B (CI)
    );

    or u_co (CO, g, t);

    // Next registered value is simply the current combinational result.
    always_comb begin
        res_d    = '0;
        res_d.s  = S;
        res_d.co = CO;
    end

    // Capture the result on every rising edge; reset clears it immediately.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    assign S_Q  = res_q.s;
    assign CO_Q = res_q.co;

endmodule : full_adder

// File: tb/tb_full_adder.sv
// Directed self-checking bench for full_adder.
`timescale 1ns/1ps

module tb_full_adder;

    logic CLK;
    logic RST;
    logic A;
    logic B;
    logic CI;
    logic S;
    logic CO;
    logic S_Q;
    logic CO_Q;

    int unsigned checks;
    int unsigned errors;

    // Truth table indexed by {CI,B,A}; order 000,100,010,110,001,101,011,111 as (A,B,CI).
    logic [7:0] exp_s_tbl;
    logic [7:0] exp_co_tbl;

    full_adder dut (
        .CLK  (CLK),
        .RST  (RST),
        .A    (A),
        .B    (B),
        .CI   (CI),
        .S    (S),
        .CO   (CO),
        .S_Q  (S_Q),
        .CO_Q (CO_Q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        exp_s_tbl  = 8'b1001_0110;
        exp_co_tbl = 8'b1110_1000;

        // Reset state
        RST = 1'b0;
        A   = 1'b0;
        B   = 1'b0;
        CI  = 1'b0;
        #1;
        check("reset_s_q", S_Q, 1'b0);
        check("reset_co_q", CO_Q, 1'b0);

        // Reset independence: sweep under reset across several clock edges
        for (int i = 0; i < 8; i++) begin
            A  = i[0];
            B  = i[1];
            CI = i[2];
            #5;
            check($sformatf("rst_sweep_s_%0d", i), S, exp_s_tbl[i]);
            check($sformatf("rst_sweep_co_%0d", i), CO, exp_co_tbl[i]);
            check($sformatf("rst_sweep_s_q_%0d", i), S_Q, 1'b0);
            check($sformatf("rst_sweep_co_q_%0d", i), CO_Q, 1'b0);
        end

        // Exhaustive combinational check with reset released
        RST = 1'b1;
        for (int i = 0; i < 8; i++) begin
            A  = i[0];
            B  = i[1];
            CI = i[2];
            #5;
            check($sformatf("comb_s_%0d", i), S, exp_s_tbl[i]);
            check($sformatf("comb_co_%0d", i), CO, exp_co_tbl[i]);
        end

        // Registered latency: start from cleared registers
        RST = 1'b0;
        A   = 1'b1;
        B   = 1'b1;
        CI  = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("lat_pre_s_q", S_Q, 1'b0);
        check("lat_pre_co_q", CO_Q, 1'b0);
        @(posedge CLK);
        #1;
        check("lat_e1_s_q", S_Q, 1'b0);
        check("lat_e1_co_q", CO_Q, 1'b1);
        CI = 1'b1;
        #1;
        check("lat_hold_s_q", S_Q, 1'b0);
        check("lat_hold_co_q", CO_Q, 1'b1);
        @(posedge CLK);
        #1;
        check("lat_e2_s_q", S_Q, 1'b1);
        check("lat_e2_co_q", CO_Q, 1'b1);

        // Asynchronous reset between edges
        @(negedge CLK);
        #2;
        RST = 1'b0;
        #1;
        check("arst_s_q", S_Q, 1'b0);
        check("arst_co_q", CO_Q, 1'b0);
        check("arst_s", S, 1'b1);
        check("arst_co", CO, 1'b1);
        @(posedge CLK);
        #1;
        check("arst_hold_s_q", S_Q, 1'b0);
        check("arst_hold_co_q", CO_Q, 1'b0);

        // Reset release: nothing changes until the next rising edge
        A  = 1'b1;
        B  = 1'b0;
        CI = 1'b1;
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("rel_pre_s_q", S_Q, 1'b0);
        check("rel_pre_co_q", CO_Q, 1'b0);
        check("rel_s", S, 1'b0);
        check("rel_co", CO, 1'b1);
        @(posedge CLK);
        #1;
        check("rel_e1_s_q", S_Q, 1'b0);
        check("rel_e1_co_q", CO_Q, 1'b1);

        // Follow-up capture of a different value
        A  = 1'b0;
        B  = 1'b1;
        CI = 1'b0;
        @(posedge CLK);
        #1;
        check("cap_s_q", S_Q, 1'b1);
        check("cap_co_q", CO_Q, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_full_adder
